// File: rtl/fix_to_fp_11_20.sv
// Signed 32-bit fixed-point to FloPoCo float (11-bit exponent, 20-bit fraction), one transaction at a time.
// Define FIX2FP_LZC_FAST_EN for single-cycle normalisation via a priority encoder; default is iterative shifting.
module fix_to_fp_11_20 #(
  parameter int IN_WIDTH  = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [33:0]         out_data
);

  typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, DONE} state_t;

  localparam logic [10:0] EXP_BASE = 11'(1023 + 31 - FRAC_BITS);

  state_t      state, state_nxt;
  logic [31:0] mag;
  logic [4:0]  lz;
  logic        sign;

  logic [10:0] exp_c;
  logic [10:0] exp_r;
  logic [20:0] frac_sum;
  logic        rnd_up;

`ifdef FIX2FP_LZC_FAST_EN
  logic [4:0] lz_fast;
  logic       lz_found;

  always_comb begin
    lz_fast  = '0;
    lz_found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (!lz_found && mag[31-i]) begin
        lz_fast  = 5'(i);
        lz_found = 1'b1;
      end
    end
  end
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = ABS;
      ABS:   state_nxt = (mag == '0) ? DONE : NORM;
`ifdef FIX2FP_LZC_FAST_EN
      NORM:  state_nxt = ROUND;
`else
      NORM:  if (mag[31]) state_nxt = ROUND;
`endif
      ROUND: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Round-to-nearest-even on the normalised magnitude; a carry out of the fraction bumps the exponent.
  always_comb begin
    exp_c    = EXP_BASE - {6'd0, lz};
    rnd_up   = mag[10] & ((|mag[9:0]) | mag[11]);
    frac_sum = {1'b0, mag[30:11]} + {20'd0, rnd_up};
    exp_r    = exp_c + {10'd0, frac_sum[20]};
  end

  // mag first holds the raw operand, then its magnitude, then the normalised value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag      <= '0;
      lz       <= '0;
      sign     <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag <= in_data;
            lz  <= '0;
          end
        end
        ABS: begin
          sign <= mag[31];
          mag  <= mag[31] ? (~mag + 32'd1) : mag;
          if (mag == '0) out_data <= '0;
        end
        NORM: begin
`ifdef FIX2FP_LZC_FAST_EN
          mag <= mag << lz_fast;
          lz  <= lz_fast;
`else
          if (!mag[31]) begin
            mag <= mag << 1;
            lz  <= lz + 5'd1;
          end
`endif
        end
        ROUND: out_data <= {2'b01, sign, exp_r, frac_sum[19:0]};
        default: ;
      endcase
    end
  end

endmodule
